// File: rtl/uart_packet_pkg.sv
// Shared types and defaults for the UART packet decoder: FSM states, error codes
// and the default sync marker.
package uart_packet_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHECK,
      ST_HOLD
   } state_e;

   typedef enum logic [1:0] {
      ERR_CHECKSUM = 2'd0,
      ERR_LENGTH   = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_OVERRUN  = 2'd3
   } err_code_e;

endpackage

// File: rtl/uart_packet_buffer.sv
// Payload store: register array with a synchronous write port and an
// asynchronous read port. Contents survive reset.
module uart_packet_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_packet_decoder.sv
// Frames the UART byte stream (SYNC, CMD, LEN, payload, CHK) into validated
// packets held until the host acknowledges them; errors are reported as strobes.
module uart_packet_decoder
   import uart_packet_pkg::*;
#(
   parameter int         MAX_PAYLOAD    = 16,
   parameter int         TIMEOUT_CYCLES = 100_000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   localparam int        PW             = $clog2(MAX_PAYLOAD + 1),
   localparam int        AW             = $clog2(MAX_PAYLOAD)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rx_valid_in,
   input  logic [7:0]    rx_byte_in,
   output logic          pkt_valid_out,
   output logic [7:0]    pkt_cmd_out,
   output logic [PW-1:0] pkt_len_out,
   input  logic [AW-1:0] rd_addr_in,
   output logic [7:0]    rd_data_out,
   input  logic          pkt_ack_in,
   output logic          err_valid_out,
   output logic [1:0]    err_code_out,
   output logic          busy_out
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   state_e        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [PW-1:0] len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    xor_q, xor_d;
   logic [CW-1:0] gap_q, gap_d;
   logic          err_valid_q, err_valid_d;
   err_code_e     err_code_q, err_code_d;
   logic          busy_q, busy_d;
   logic          pkt_valid_q, pkt_valid_d;
   logic          timed;
   logic          buf_we;

   assign timed  = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                   (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
   assign buf_we = (state_q == ST_PAYLOAD) && rx_valid_in;

   uart_packet_buffer #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buffer (
      .clk_i   (clk_in),
      .we_i    (buf_we),
      .waddr_i (idx_q),
      .wdata_i (rx_byte_in),
      .raddr_i (rd_addr_in),
      .rdata_o (rd_data_out)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      idx_d       = idx_q;
      xor_d       = xor_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      gap_d       = (timed && !rx_valid_in) ? gap_q + CW'(1) : '0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid_in && rx_byte_in == SYNC_BYTE) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (rx_valid_in) begin
               cmd_d   = rx_byte_in;
               xor_d   = rx_byte_in;
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_valid_in) begin
               xor_d = xor_q ^ rx_byte_in;
               if (int'(rx_byte_in) > MAX_PAYLOAD) begin
                  state_d     = ST_IDLE;
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_LENGTH;
               end else begin
                  len_d   = PW'(rx_byte_in);
                  idx_d   = '0;
                  state_d = (rx_byte_in == 8'h00) ? ST_CHECK : ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid_in) begin
               xor_d = xor_q ^ rx_byte_in;
               idx_d = idx_q + AW'(1);
               if (PW'(idx_q) == len_q - PW'(1)) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (rx_valid_in) begin
               if (rx_byte_in == xor_q) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d     = ST_IDLE;
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_CHECKSUM;
               end
            end
         end
         ST_HOLD: begin
            // A byte arriving with the ack is treated as the first IDLE byte.
            if (pkt_ack_in) begin
               state_d = (rx_valid_in && rx_byte_in == SYNC_BYTE) ? ST_CMD : ST_IDLE;
            end else if (rx_valid_in) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_OVERRUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Expiry when the gap count would reach TIMEOUT_CYCLES-1; a byte this cycle wins.
      if (timed && !rx_valid_in && gap_q == CW'(TIMEOUT_CYCLES - 2)) begin
         state_d     = ST_IDLE;
         err_valid_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
      end

      busy_d      = (state_d != ST_IDLE);
      pkt_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         xor_q       <= '0;
         gap_q       <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_CHECKSUM;
         busy_q      <= 1'b0;
         pkt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         xor_q       <= xor_d;
         gap_q       <= gap_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         busy_q      <= busy_d;
         pkt_valid_q <= pkt_valid_d;
      end
   end

   assign pkt_valid_out = pkt_valid_q;
   assign pkt_cmd_out   = cmd_q;
   assign pkt_len_out   = len_q;
   assign err_valid_out = err_valid_q;
   assign err_code_out  = err_code_q;
   assign busy_out      = busy_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder: expected packets and errors are queued
// as frames are sent and matched against DUT events by a negedge monitor.
module tb_uart_packet_decoder;

   localparam int MAXP = 16;
   localparam int TMO  = 50;
   localparam int PW   = $clog2(MAXP + 1);
   localparam int AW   = $clog2(MAXP);

   logic          clk_in;
   logic          rst_in;
   logic          rx_valid_in;
   logic [7:0]    rx_byte_in;
   logic          pkt_valid_out;
   logic [7:0]    pkt_cmd_out;
   logic [PW-1:0] pkt_len_out;
   logic [AW-1:0] rd_addr_in;
   logic [7:0]    rd_data_out;
   logic          pkt_ack_in;
   logic          err_valid_out;
   logic [1:0]    err_code_out;
   logic          busy_out;

   uart_packet_decoder #(
      .MAX_PAYLOAD    (MAXP),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_BYTE      (8'hA5)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rx_valid_in   (rx_valid_in),
      .rx_byte_in    (rx_byte_in),
      .pkt_valid_out (pkt_valid_out),
      .pkt_cmd_out   (pkt_cmd_out),
      .pkt_len_out   (pkt_len_out),
      .rd_addr_in    (rd_addr_in),
      .rd_data_out   (rd_data_out),
      .pkt_ack_in    (pkt_ack_in),
      .err_valid_out (err_valid_out),
      .err_code_out  (err_code_out),
      .busy_out      (busy_out)
   );

   typedef struct {
      bit         is_err;
      logic [7:0] cmd;
      int         len;
      logic [1:0] code;
      logic [7:0] pl [MAXP];
   } ev_t;

   ev_t        sb [$];
   ev_t        mev;
   logic [7:0] frame_pl [$];
   logic [7:0] held_pl [MAXP];
   int         held_len = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   bit         prev_pv = 1'b0;
   int         lat;

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: every error strobe and every rising pkt_valid_out consumes one expectation.
   always @(negedge clk_in) begin
      if (err_valid_out === 1'b1) begin
         chk("err_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mev = sb.pop_front();
            chk("err_is_error", 32'(mev.is_err), 1);
            chk("err_code", err_code_out, mev.code);
         end
      end
      if (pkt_valid_out === 1'b1 && !prev_pv) begin
         chk("pkt_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mev = sb.pop_front();
            chk("pkt_is_packet", 32'(mev.is_err), 0);
            chk("pkt_cmd", pkt_cmd_out, mev.cmd);
            chk("pkt_len", pkt_len_out, mev.len);
            held_pl  = mev.pl;
            held_len = mev.len;
         end
      end
      prev_pv = (pkt_valid_out === 1'b1);
   end

   task automatic send_byte(input logic [7:0] b);
      rx_valid_in = 1'b1;
      rx_byte_in  = b;
      @(posedge clk_in);
      #1;
      rx_valid_in = 1'b0;
   endtask

   task automatic push_err(input logic [1:0] code);
      ev_t e;
      e.is_err = 1'b1;
      e.cmd    = '0;
      e.len    = 0;
      e.code   = code;
      foreach (e.pl[i]) e.pl[i] = '0;
      sb.push_back(e);
   endtask

   // Sends frame_pl as a packet; a corrupted checksum expects a checksum error instead.
   task automatic send_frame(input logic [7:0] cmd, input bit corrupt, input bit with_sync);
      ev_t        e;
      logic [7:0] c;
      c = cmd ^ 8'(frame_pl.size());
      foreach (frame_pl[i]) c ^= frame_pl[i];
      e.is_err = corrupt;
      e.cmd    = cmd;
      e.len    = frame_pl.size();
      e.code   = 2'd0;
      foreach (e.pl[i]) e.pl[i] = '0;
      foreach (frame_pl[i]) e.pl[i] = frame_pl[i];
      sb.push_back(e);
      if (with_sync) send_byte(8'hA5);
      send_byte(cmd);
      send_byte(8'(frame_pl.size()));
      foreach (frame_pl[i]) send_byte(frame_pl[i]);
      send_byte(corrupt ? (c ^ 8'h01) : c);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk_in);
         n++;
      end
      #1;
      chk("drain_events", sb.size(), 0);
   endtask

   task automatic read_check();
      for (int i = 0; i < held_len; i++) begin
         rd_addr_in = AW'(i);
         #1;
         chk("rd_data", rd_data_out, held_pl[i]);
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic ack();
      pkt_ack_in = 1'b1;
      @(posedge clk_in);
      #1;
      pkt_ack_in = 1'b0;
      chk("ack_release", pkt_valid_out, 0);
   endtask

   initial begin
      rst_in      = 1'b1;
      rx_valid_in = 1'b0;
      rx_byte_in  = '0;
      rd_addr_in  = '0;
      pkt_ack_in  = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_pkt_valid", pkt_valid_out, 0);
      chk("rst_cmd", pkt_cmd_out, 0);
      chk("rst_len", pkt_len_out, 0);
      chk("rst_err_valid", err_valid_out, 0);
      chk("rst_err_code", err_code_out, 0);
      chk("rst_busy", busy_out, 0);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;

      // Basic three-byte payload frame
      frame_pl = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, 1'b0, 1'b1);
      drain();
      chk("hold_busy", busy_out, 1);
      read_check();
      ack();
      chk("idle_busy", busy_out, 0);

      // Zero-length frame, then the same frame with a bad checksum
      frame_pl = {};
      send_frame(8'h20, 1'b0, 1'b1);
      drain();
      ack();
      send_frame(8'h20, 1'b1, 1'b1);
      drain();
      chk("badchk_no_pkt", pkt_valid_out, 0);

      // Oversized length, then a frame carrying SYNC values as data
      push_err(2'd1);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'(MAXP + 1));
      chk("len_err_busy", busy_out, 0);
      drain();
      frame_pl = '{8'hA5, 8'h5A};
      send_frame(8'hA5, 1'b0, 1'b1);
      drain();
      read_check();
      ack();

      // Full-capacity payload
      frame_pl = {};
      for (int i = 0; i < MAXP; i++) frame_pl.push_back(8'(i * 8'h13 + 8'h07));
      send_frame(8'h3C, 1'b0, 1'b1);
      drain();
      read_check();
      ack();

      // Timeout: error strobe registered on the 49th edge after the CMD byte
      push_err(2'd2);
      send_byte(8'hA5);
      send_byte(8'h10);
      lat = -1;
      for (int k = 1; k <= 60 && lat < 0; k++) begin
         @(posedge clk_in);
         #1;
         if (err_valid_out === 1'b1) lat = k;
      end
      chk("timeout_latency", lat, 49);
      chk("timeout_busy", busy_out, 0);
      drain();

      // A byte on the expiry cycle keeps the packet alive
      frame_pl = {};
      sb.push_back('{is_err: 1'b0, cmd: 8'h10, len: 0, code: 2'd0, pl: '{default: 8'h00}});
      send_byte(8'hA5);
      send_byte(8'h10);
      repeat (48) @(posedge clk_in);
      #1;
      send_byte(8'h00);
      send_byte(8'h10);
      drain();
      ack();

      // Overrun while holding, then ack coincident with a new SYNC
      frame_pl = '{8'h77};
      send_frame(8'h40, 1'b0, 1'b1);
      drain();
      push_err(2'd3);
      push_err(2'd3);
      send_byte(8'h01);
      send_byte(8'h02);
      drain();
      chk("overrun_hold_valid", pkt_valid_out, 1);
      chk("overrun_hold_cmd", pkt_cmd_out, 8'h40);
      read_check();
      pkt_ack_in  = 1'b1;
      rx_valid_in = 1'b1;
      rx_byte_in  = 8'hA5;
      @(posedge clk_in);
      #1;
      pkt_ack_in  = 1'b0;
      rx_valid_in = 1'b0;
      chk("ack_sync_busy", busy_out, 1);
      chk("ack_sync_valid", pkt_valid_out, 0);
      chk("ack_sync_no_err", err_valid_out, 0);
      frame_pl = '{8'hC1, 8'hC2};
      send_frame(8'h50, 1'b0, 1'b0);
      drain();
      read_check();
      ack();

      // Reset mid-payload, then noise before a good frame
      send_byte(8'hA5);
      send_byte(8'h60);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      rst_in = 1'b1;
      #1;
      chk("midrst_busy", busy_out, 0);
      chk("midrst_cmd", pkt_cmd_out, 0);
      chk("midrst_len", pkt_len_out, 0);
      chk("midrst_err_code", err_code_out, 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("noise_busy", busy_out, 0);
      frame_pl = '{8'h9C};
      send_frame(8'h70, 1'b0, 1'b1);
      drain();
      read_check();
      ack();

      repeat (5) @(posedge clk_in);
      #1;
      chk("end_queue_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_packet_decoder.md
# uart_packet_decoder

Frames the raw byte stream from the UART receiver into validated command packets. Consumes the receiver's one-cycle byte strobe, hunts for a sync byte, collects command, length, payload and checksum, and presents each good packet to the host logic through a hold-until-acknowledged buffer. Sits between the UART receiver and the command dispatch logic; bad, late or unconsumed traffic is dropped and reported on a one-cycle error strobe.

## Interface
- MAX_PAYLOAD, 16: payload capacity in bytes (≥2); PW = $clog2(MAX_PAYLOAD+1), AW = $clog2(MAX_PAYLOAD)
- TIMEOUT_CYCLES, 100_000: maximum idle gap between bytes inside a packet (1 ms at 100 MHz)
- SYNC_BYTE, 8'hA5: packet start marker

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- rx_valid_in  in  1  one-cycle strobe, byte available (receiver new_data_out)
- rx_byte_in  in  8  received byte, valid with rx_valid_in
- pkt_valid_out  out  1  a validated packet is held
- pkt_cmd_out  out  8  command byte of held packet
- pkt_len_out  out  PW  payload length of held packet
- rd_addr_in  in  AW  payload read index
- rd_data_out  out  8  payload[rd_addr_in], combinational
- pkt_ack_in  in  1  host releases held packet
- err_valid_out  out  1  one-cycle error strobe
- err_code_out  out  2  0 checksum, 1 length, 2 timeout, 3 overrun; valid with err_valid_out
- busy_out  out  1  high in any state other than IDLE

## Operation
- Frame: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- States: IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD.
- IDLE: byte == SYNC_BYTE -> CMD; any other byte is discarded silently.
- CMD: latch cmd, xor := byte -> LEN.
- LEN: LEN > MAX_PAYLOAD -> IDLE, error 1. LEN == 0 -> CHECK. Otherwise -> PAYLOAD, index := 0. xor ^= byte in every case.
- PAYLOAD: write byte to buffer[index], xor ^= byte, index++. Go to CHECK after byte LEN-1.
- CHECK: byte == xor -> HOLD, pkt_valid_out=1. Mismatch -> IDLE, error 0.
- HOLD: cmd/len/buffer stable. pkt_ack_in -> IDLE. Any byte arriving in HOLD without ack is discarded, error 3, one strobe per byte.
- A SYNC_BYTE value inside CMD/LEN/PAYLOAD/CHECK is data. No resynchronisation.
- Timeout: the gap counter runs in CMD, LEN, PAYLOAD and CHECK. It clears on every accepted byte and on state entry. Reaching TIMEOUT_CYCLES-1 without a byte -> IDLE, error 2.
- Simultaneous events:
  - byte and timeout in the same cycle: the byte wins, counter clears.
  - pkt_ack_in and byte in the same cycle in HOLD: the ack takes effect, and the byte is evaluated as an IDLE byte (SYNC enters CMD directly). No overrun is reported.
- pkt_ack_in outside HOLD is ignored.

## Timing
- All state and outputs are registered except rd_data_out.
- pkt_valid_out rises one cycle after the CHK strobe and falls one cycle after pkt_ack_in.
- err_valid_out is high exactly one cycle, the cycle after the causing byte or timeout expiry. err_code_out is held until the next error.
- rd_data_out reflects rd_addr_in in the same cycle. It is defined only for rd_addr_in < pkt_len_out while pkt_valid_out=1.
- Throughput is one byte per cycle, so back-to-back strobes are legal.
- Reset: immediately forces state IDLE, pkt_valid_out=0, pkt_cmd_out=0, pkt_len_out=0, err_valid_out=0, err_code_out=0, busy_out=0, and clears the counters and xor. Buffer contents are not cleared. Reset mid-packet or mid-HOLD discards the packet without an error.

## Structure
- Package uart_packet_pkg holds:
  - state enum
  - err_code enum (ERR_CHECKSUM, ERR_LENGTH, ERR_TIMEOUT, ERR_OVERRUN)
  - SYNC_BYTE default
- Sub-module uart_packet_buffer: MAX_PAYLOAD×8 register array, synchronous write port, asynchronous read port, no reset.
- The decoder FSM, xor accumulator, index and gap counter live in the top module.

## Test plan
- Frame A5 10 03 11 22 33 with CHK 10^03^11^22^33 = 0x13 -> pkt_valid_out=1, cmd=0x10, len=3, reads of 0/1/2 return 11/22/33. Ack -> pkt_valid_out=0 next cycle.
- Frame A5 20 00 20 (LEN=0) -> pkt_valid_out=1, len=0. Same frame with CHK 0x21 -> err code 0, no pkt_valid_out.
- A5 01 with LEN=MAX_PAYLOAD+1 -> err code 1, busy_out=0. The next good frame is accepted.
- With TIMEOUT_CYCLES=50: A5 10, then silence -> err code 2 exactly 49 cycles after the CMD strobe. A byte arriving on the expiry cycle prevents the error.
- While holding a packet, send 2 bytes -> two err code 3 strobes. Send pkt_ack_in coincident with A5 -> no error, busy_out stays 1, and the following frame is decoded.
- Assert rst_in mid-PAYLOAD -> outputs zero immediately. Noise bytes 00 FF before A5 are ignored, and the subsequent frame decodes.
